// File: rtl/tick_counter_bank_pkg.sv
// Shared constants and helpers for the tick counter bank.
package tick_bank_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Channel-select width: clog2 with a floor of one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One channel: programmable prescaler producing a tick enable that steps an up/down counter.
module tick_channel
  import tick_bank_pkg::*;
#(
  parameter int                    PRESCALE_W  = 24,
  parameter int                    OUT_W       = 4,
  parameter logic [PRESCALE_W-1:0] DEFAULT_DIV = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  dir_i,
  input  logic                  load_i,
  input  logic [PRESCALE_W-1:0] load_val_i,
  output logic                  tick_o,
  output logic                  wrap_o,
  output logic [OUT_W-1:0]      cnt_o,
  output logic                  at_wrap_o
);

  logic [PRESCALE_W-1:0] pre_q, pre_d, div_q, div_d;
  logic [OUT_W-1:0]      cnt_q, cnt_d;
  logic                  tick_q, tick_d, wrap_q, wrap_d;

  assign at_wrap_o = en_i & (pre_q == div_q);

  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    div_d  = load_i ? load_val_i : div_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (clr_i) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (en_i) begin
      if (pre_q == div_q) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (dir_i == DIR_UP) begin
          cnt_d  = cnt_q + 1'b1;
          wrap_d = &cnt_q;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          wrap_d = (cnt_q == '0);
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    // A new divide value always restarts the period from zero.
    if (load_i) pre_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q  <= '0;
      div_q  <= DEFAULT_DIV;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign tick_o = tick_q;
  assign wrap_o = wrap_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/tick_counter_bank.sv
// Bank of tick channels with a single-slot divide-value config port applied at channel wrap points.
module tick_counter_bank
  import tick_bank_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          PRESCALE_W  = 24,
  parameter int          OUT_W       = 4,
  parameter int unsigned DEFAULT_DIV = 2**PRESCALE_W - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         en,
  input  logic [NUM_CH-1:0]         clr,
  input  logic [NUM_CH-1:0]         dir,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [sel_w(NUM_CH)-1:0]  cfg_ch,
  input  logic [PRESCALE_W-1:0]     cfg_div,
  output logic [NUM_CH-1:0]         tick_o,
  output logic [NUM_CH-1:0]         wrap_o,
  output logic [NUM_CH*OUT_W-1:0]   cnt_o
);

  localparam int                    CH_W     = sel_w(NUM_CH);
  localparam logic [PRESCALE_W-1:0] DIV_RST  = PRESCALE_W'(DEFAULT_DIV);
  localparam logic [CH_W:0]         NUM_CH_L = (CH_W+1)'(NUM_CH);

  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [PRESCALE_W-1:0] div;
  } cfg_req_t;

  logic              pend_vld_q, pend_vld_d;
  cfg_req_t          pend_q, pend_d;
  logic [NUM_CH-1:0] load, at_wrap;
  logic              pend_oor;

  // Ready is purely the slot state, so it never depends on cfg_valid.
  assign cfg_ready = ~pend_vld_q;
  assign pend_oor  = pend_vld_q & ({1'b0, pend_q.ch} >= NUM_CH_L);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign load[c] = pend_vld_q & (pend_q.ch == CH_W'(c)) & (at_wrap[c] | clr[c] | ~en[c]);

    tick_channel #(
      .PRESCALE_W (PRESCALE_W),
      .OUT_W      (OUT_W),
      .DEFAULT_DIV(DIV_RST)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en[c]),
      .clr_i     (clr[c]),
      .dir_i     (dir[c]),
      .load_i    (load[c]),
      .load_val_i(pend_q.div),
      .tick_o    (tick_o[c]),
      .wrap_o    (wrap_o[c]),
      .cnt_o     (cnt_o[c*OUT_W +: OUT_W]),
      .at_wrap_o (at_wrap[c])
    );
  end

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    if (cfg_valid && cfg_ready) begin
      pend_vld_d = 1'b1;
      pend_d     = '{ch: cfg_ch, div: cfg_div};
    end else if ((|load) || pend_oor) begin
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end

endmodule

// File: tb/tb_tick_counter_bank.sv
// Self-checking bench for tick_counter_bank: directed vectors, corner sequences, random run vs. model.
module tb_tick_counter_bank;

  localparam int NC  = 3;
  localparam int PW  = 4;
  localparam int OW  = 4;
  localparam int DEF = 15;
  localparam int MOD = 1 << OW;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] en, clr, dir;
  logic          cfg_valid, cfg_ready;
  logic [1:0]    cfg_ch;
  logic [PW-1:0] cfg_div;
  logic [NC-1:0] tick_o, wrap_o;
  logic [NC*OW-1:0] cnt_o;

  tick_counter_bank #(.NUM_CH(NC), .PRESCALE_W(PW), .OUT_W(OW), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .dir(dir),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .tick_o(tick_o), .wrap_o(wrap_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference model: per-channel phase/period/count as integers, config slot as a flag.
  int m_pre[NC], m_div[NC], m_cnt[NC];
  bit m_tick[NC], m_wrap[NC];
  bit m_pv, m_acc;
  int m_pch, m_pdiv;

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_pre[c] = 0; m_div[c] = DEF; m_cnt[c] = 0; m_tick[c] = 0; m_wrap[c] = 0;
    end
    m_pv = 0; m_acc = 0;
  endfunction

  function automatic void model_step();
    bit ap[NC];
    bit any_ap = 0;
    int n;
    m_acc = 0;
    for (int c = 0; c < NC; c++)
      ap[c] = m_pv && (m_pch == c) && (clr[c] || !en[c] || m_pre[c] == m_div[c]);
    for (int c = 0; c < NC; c++) begin
      m_tick[c] = 0; m_wrap[c] = 0;
      if (clr[c]) begin
        m_pre[c] = 0; m_cnt[c] = 0;
      end else if (en[c]) begin
        if (m_pre[c] == m_div[c]) begin
          m_pre[c]  = 0;
          m_tick[c] = 1;
          n = m_cnt[c] + (dir[c] ? -1 : 1);
          m_wrap[c] = (n < 0) || (n >= MOD);
          m_cnt[c]  = (n + MOD) % MOD;
        end else begin
          m_pre[c]++;
        end
      end
      if (ap[c]) begin
        m_div[c] = m_pdiv; m_pre[c] = 0; any_ap = 1;
      end
    end
    if (m_pv) begin
      if (any_ap || m_pch >= NC) m_pv = 0;
    end else if (cfg_valid) begin
      m_pv = 1; m_pch = int'(cfg_ch); m_pdiv = int'(cfg_div); m_acc = 1;
    end
  endfunction

  task automatic compare_all();
    check("ready", cfg_ready, !m_pv);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("tick%0d", c), tick_o[c], m_tick[c]);
      check($sformatf("wrap%0d", c), wrap_o[c], m_wrap[c]);
      check($sformatf("cnt%0d", c), cnt_o[c*OW +: OW], m_cnt[c]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    en = '0; clr = '0; dir = '0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0;
  endtask

  // Asserts reset without waiting for an edge, checks the cleared outputs, then releases.
  task automatic do_reset();
    rst = 0;
    model_reset();
    #1;
    check("rst_ready", cfg_ready, 1);
    check("rst_tick", tick_o, 0);
    check("rst_wrap", wrap_o, 0);
    check("rst_cnt", cnt_o, 0);
    idle();
    @(negedge clk);
    rst = 1;
  endtask

  typedef struct {
    int div; bit dir; int n;
    int exp_cnt; bit exp_tick; bit exp_wrap;
  } vec_t;

  vec_t vt[9];

  initial begin
    int acc_edge;
    bit rdy;
    vt[0] = '{0, 0, 5, 5, 1, 0};
    vt[1] = '{3, 0, 10, 2, 0, 0};
    vt[2] = '{3, 1, 12, 13, 1, 0};
    vt[3] = '{1, 1, 3, 15, 0, 0};
    vt[4] = '{0, 0, 17, 1, 1, 0};
    vt[5] = '{15, 0, 32, 2, 1, 0};
    vt[6] = '{2, 1, 9, 13, 1, 0};
    vt[7] = '{0, 0, 16, 0, 1, 1};
    vt[8] = '{0, 1, 1, 15, 1, 1};

    idle();
    do_reset();

    // Default divide: tick every 16 cycles, wrap on 15->0.
    en = '1;
    for (int i = 1; i <= 256; i++) begin
      step();
      check("def_tick", tick_o[0], (i % 16) == 0);
      check("def_cnt", cnt_o[3:0], (i / 16) % 16);
      check("def_wrap", wrap_o[0], i == 256);
    end

    // Program ch0 while disabled, then count n cycles.
    foreach (vt[r]) begin
      do_reset();
      cfg_valid = 1; cfg_ch = 0; cfg_div = PW'(vt[r].div);
      step();
      check("vec_busy", cfg_ready, 0);
      cfg_valid = 0;
      step();
      check("vec_ready", cfg_ready, 1);
      en[0] = 1; dir[0] = vt[r].dir;
      repeat (vt[r].n) step();
      check($sformatf("vec%0d_cnt", r), cnt_o[3:0], vt[r].exp_cnt);
      check($sformatf("vec%0d_tick", r), tick_o[0], vt[r].exp_tick);
      check($sformatf("vec%0d_wrap", r), wrap_o[0], vt[r].exp_wrap);
    end

    // Live reprogram of a running channel: held until its wrap.
    do_reset();
    en[0] = 1;
    repeat (5) step();
    cfg_valid = 1; cfg_ch = 0; cfg_div = 4'd3;
    for (int e = 6; e <= 24; e++) begin
      step();
      if (e == 6) cfg_valid = 0;
      check("live_ready", cfg_ready, e >= 16);
      check("live_tick", tick_o[0], (e == 16) || (e == 20) || (e == 24));
    end

    // Disabled-channel write then down-count every cycle.
    do_reset();
    cfg_valid = 1; cfg_ch = 1; cfg_div = 0;
    step();
    check("dis_busy", cfg_ready, 0);
    cfg_valid = 0;
    step();
    check("dis_ready", cfg_ready, 1);
    en[1] = 1; dir[1] = 1;
    step();
    check("dis_cnt_a", cnt_o[7:4], 15);
    check("dis_wrap_a", wrap_o[1], 1);
    step();
    check("dis_cnt_b", cnt_o[7:4], 14);
    check("dis_wrap_b", wrap_o[1], 0);

    // Back-pressure: a second write waits for the first to apply.
    do_reset();
    en = '1;
    repeat (3) step();
    cfg_valid = 1; cfg_ch = 0; cfg_div = 4'd7;
    step();
    cfg_ch = 1; cfg_div = 4'd2;
    acc_edge = -1;
    for (int e = 5; e <= 44; e++) begin
      rdy = cfg_ready;
      step();
      if (rdy) begin acc_edge = e; break; end
    end
    check("bp_accept_edge", acc_edge, 17);
    cfg_valid = 0;
    for (int k = 0; k < 40 && !cfg_ready; k++) step();
    check("bp_drained", cfg_ready, 1);
    cfg_valid = 1; cfg_ch = 2'd3; cfg_div = 4'd1;
    step();
    check("oor_busy", cfg_ready, 0);
    cfg_valid = 0;
    step();
    check("oor_ready", cfg_ready, 1);
    repeat (40) step();

    // Clear on a wrap cycle with a pending write to the same channel.
    do_reset();
    en[0] = 1;
    repeat (20) step();
    cfg_valid = 1; cfg_ch = 0; cfg_div = 4'd2;
    step();
    cfg_valid = 0;
    repeat (10) step();
    clr[0] = 1;
    step();
    check("clr_cnt", cnt_o[3:0], 0);
    check("clr_tick", tick_o[0], 0);
    check("clr_wrap", wrap_o[0], 0);
    check("clr_ready", cfg_ready, 1);
    clr[0] = 0;
    for (int e = 33; e <= 35; e++) begin
      step();
      check("clr_newdiv_tick", tick_o[0], e == 35);
    end
    check("clr_newdiv_cnt", cnt_o[3:0], 1);

    // Asynchronous reset mid-count with a config pending.
    do_reset();
    en = '1;
    repeat (20) step();
    cfg_valid = 1; cfg_ch = 0; cfg_div = 4'd1;
    step();
    cfg_valid = 0;
    repeat (4) step();
    #2;
    do_reset();
    en = '1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("post_rst_tick", tick_o[0], i == 16);
    end

    // Random traffic against the model; requests held until accepted.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en  = NC'($urandom);
      clr = ($urandom_range(0, 15) == 0) ? NC'($urandom) : '0;
      dir = NC'($urandom);
      if (!(cfg_valid && !m_acc)) begin
        cfg_valid = ($urandom_range(0, 3) == 0);
        cfg_ch    = 2'($urandom_range(0, 3));
        cfg_div   = ($urandom_range(0, 7) == 0) ? PW'($urandom_range(0, 15)) : PW'($urandom_range(0, 4));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
